shiftadd_mult_ctrl: RTL and testbench

SHIFTADD_MULT_CTRL -- requirements
Module: shiftadd_mult_ctrl_haleyorr2027

---
 rtl/shiftadd_mult_ctrl.sv | 81 ++++++++
 tb/tb_shiftadd_mult_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shiftadd_mult_ctrl.sv
// Sequential shift-add multiplier controller. The add/no-add choice is made by
// an external 2:1 mux; this block sources both candidates and consumes the pick.
module shiftadd_mult_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           mux_sel,
  output logic [2*N:0]   mux_in0,
  output logic [2*N:0]   mux_in1,
  input  logic [2*N:0]   mux_out,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int W  = 2*N + 1;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    r;
  logic [N-1:0]    m;
  logic [CW-1:0]   cnt;
  logic            last;

  // The mux output LSB is shifted out every step and never needed.
  logic mux_out_unused;
  assign mux_out_unused = mux_out[0];

  assign last    = (cnt == CW'(N-1));
  assign mux_sel = r[0];
  assign mux_in0 = r;
  assign mux_in1 = r + {1'b0, m, {N{1'b0}}};
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r       <= '0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r   <= {{(N+1){1'b0}}, b};
          m   <= a;
          cnt <= '0;
        end
        RUN: begin
          r   <= {1'b0, mux_out[W-1:1]};
          cnt <= cnt + CW'(1);
          // Final step: the shifted value is the full 2N-bit product.
          if (last) product <= mux_out[W-1:1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftadd_mult_ctrl.sv
// Bench for shiftadd_mult_ctrl: models the external mux, scoreboards products
// and tracks the partial-product register through every RUN cycle.
module tb_shiftadd_mult_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  a, b;
  logic        mux_sel;
  logic [16:0] mux_in0, mux_in1, mux_out;
  logic        busy, done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  shiftadd_mult_ctrl #(.N(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .mux_sel(mux_sel), .mux_in0(mux_in0), .mux_in1(mux_in1), .mux_out(mux_out),
    .busy(busy), .done(done), .product(product)
  );

  assign mux_out = mux_sel ? mux_in1 : mux_in0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered at a negedge with the DUT idle; leaves at a negedge back in IDLE.
  task automatic mult_op(input logic [7:0] ta, input logic [7:0] tbv, input bit poke);
    logic [16:0] r_exp, sum, sel, full;
    logic [7:0]  m_exp;
    logic [15:0] exp_p, got_p;
    exp_p = 16'(ta) * 16'(tbv);
    full  = {1'b0, exp_p};
    exp_q.push_back(exp_p);
    a = ta; b = tbv; start = 1'b1;
    m_exp = ta; r_exp = {9'b0, tbv};
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tbv;
    for (int i = 0; i < 8; i++) begin
      if (poke && i == 2) begin start = 1'b1; a = 8'd7; b = 8'd7; end
      if (poke && i == 3) start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0)
        begin errors++; $display("FAIL run_flags cyc%0d busy=%b done=%b want 1/0", i, busy, done); end
      checks++;
      if (mux_in0 !== r_exp)
        begin errors++; $display("FAIL mux_in0 cyc%0d got %h want %h", i, mux_in0, r_exp); end
      checks++;
      if (mux_sel !== r_exp[0])
        begin errors++; $display("FAIL mux_sel cyc%0d got %b want %b", i, mux_sel, r_exp[0]); end
      sum = r_exp + {1'b0, m_exp, 8'b0};
      checks++;
      if (mux_in1 !== sum)
        begin errors++; $display("FAIL mux_in1 cyc%0d got %h want %h", i, mux_in1, sum); end
      sel   = r_exp[0] ? sum : r_exp;
      r_exp = {1'b0, sel[16:1]};
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL done_flags busy=%b done=%b want 0/1", busy, done); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty got done want queued result");
    end else begin
      got_p = exp_q.pop_front();
      if (product !== got_p)
        begin errors++; $display("FAIL product a=%h b=%h got %h want %h", ta, tbv, product, got_p); end
    end
    checks++;
    if (mux_in0 !== full)
      begin errors++; $display("FAIL r_at_done got %h want %h", mux_in0, full); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL idle_flags busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; a = 8'h5A; b = 8'hC3;
    #1;
    checks++;
    if ({busy, done, mux_sel, mux_in0, mux_in1, product} !== '0)
      begin errors++; $display("FAIL reset_state busy=%b done=%b sel=%b in0=%h in1=%h prod=%h want 0",
                               busy, done, mux_sel, mux_in0, mux_in1, product); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    mult_op(8'd13, 8'd11, 1'b0);
    mult_op(8'hFF, 8'hFF, 1'b0);
    mult_op(8'h00, 8'hA5, 1'b0);
    mult_op(8'h80, 8'h01, 1'b0);
    mult_op(8'h00, 8'h00, 1'b0);
    mult_op(8'hFF, 8'h00, 1'b0);
    mult_op(8'h01, 8'hFF, 1'b0);
  endtask

  task automatic test_ignore_start;
    mult_op(8'd3, 8'd5, 1'b1);
  endtask

  task automatic test_idle_hold;
    logic [16:0] r_hold;
    logic [15:0] p_hold;
    r_hold = mux_in0; p_hold = product;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 8'(i * 37); b = 8'(i * 91);
      @(negedge clk);
      checks++;
      if (mux_in0 !== r_hold || product !== p_hold || busy !== 1'b0)
        begin errors++; $display("FAIL idle_hold r=%h prod=%h busy=%b want %h %h 0", mux_in0, product, busy, r_hold, p_hold); end
    end
  endtask

  task automatic test_back_to_back;
    int first, ndone;
    logic [15:0] want;
    first = -1; ndone = 0;
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'h0010);
    a = 8'd2; b = 8'd3; start = 1'b1;
    for (int cyc = 0; cyc < 40 && ndone < 2; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin a = 8'd4; b = 8'd4; end
      checks++;
      if (busy && done)
        begin errors++; $display("FAIL b2b_overlap cyc%0d busy=%b done=%b", cyc, busy, done); end
      if (done) begin
        want = exp_q.pop_front();
        checks++;
        if (product !== want)
          begin errors++; $display("FAIL b2b_product got %h want %h", product, want); end
        if (ndone == 0) first = cyc;
        else begin
          checks++;
          if (cyc - first != 10)
            begin errors++; $display("FAIL b2b_spacing got %0d want 10", cyc - first); end
          start = 1'b0;
        end
        ndone++;
      end
    end
    checks++;
    if (ndone != 2)
      begin errors++; $display("FAIL b2b_timeout got %0d done pulses want 2", ndone); end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0)
      begin errors++; $display("FAIL b2b_idle busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mux_sel, mux_in0, mux_in1, product} !== '0)
      begin errors++; $display("FAIL midrun_reset busy=%b done=%b in0=%h in1=%h prod=%h want 0",
                               busy, done, mux_in0, mux_in1, product); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL midrun_no_done cyc%0d busy=%b done=%b want 0/0", i, busy, done); end
    end
    mult_op(8'd1, 8'd1, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++)
      mult_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ignore_start;
    test_idle_hold;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    checks++;
    if (exp_q.size() != 0)
      begin errors++; $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
